dna_reader: RTL and testbench

DNA_READER -- requirements
Module: dna_reader

---
 rtl/dna_reader_if.sv | 22 ++
 rtl/dna_reader.sv | 184 ++++++++++++++++++
 tb/tb_dna_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dna_reader_if.sv
// Bus bundle between the DNA block reader, the RAM controller and the downstream consumer.
// The master side is the reader; the slave side is the RAM controller plus the consumer.
interface dna_reader_if;
  logic        ram_instruction;
  logic        ram_latch;
  logic [23:1] ram_addr;
  logic [15:0] ram_data_out;
  logic        ram_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (
    output ram_instruction, ram_latch, ram_addr, dout, dout_valid,
    input  ram_data_out, ram_ready, dout_ready
  );

  modport slave (
    input  ram_instruction, ram_latch, ram_addr, dout, dout_valid,
    output ram_data_out, ram_ready, dout_ready
  );
endinterface

// File: rtl/dna_reader.sv
// Reads a block of 16-bit words from the RAM controller one transaction at a time and streams them out.
// Optional DNA_READER_CHECKSUM_EN adds a modulo-2^16 sum of all words transferred on dout.
module dna_reader #(
  parameter bit READ       = 1'b0,
  parameter bit WRITE      = 1'b1,
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:1] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
`ifdef DNA_READER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  dna_reader_if.master bus
);

  localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  if (READ == WRITE) begin : g_opcode_check
    $error("dna_reader: READ and WRITE opcodes must differ");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    OUTPUT,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [23:1]    addr;
  logic [15:0]    remaining;
  logic [WCW-1:0] wait_cnt;
  logic [23:1]    ram_addr_q;
  logic           ram_latch_q;
  logic [15:0]    dout_q;
  logic           dout_valid_q;

  logic accept;
  logic fire;
  logic capture;
  logic xfer;
  logic timeout;
  logic wait_tick;

  assign bus.ram_instruction = READ;
  assign bus.ram_latch       = ram_latch_q;
  assign bus.ram_addr        = ram_addr_q;
  assign bus.dout            = dout_q;
  assign bus.dout_valid      = dout_valid_q;

  // The wait counter spans WAIT_LOW and WAIT_HIGH together; a response on the last
  // allowed cycle still wins over the timeout.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fire       = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    timeout    = 1'b0;
    wait_tick  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (word_count == 16'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ram_ready) begin
          fire       = 1'b1;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FINISH;
        end else begin
          wait_tick = 1'b1;
          if (!bus.ram_ready) begin
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (bus.ram_ready) begin
          capture    = 1'b1;
          state_next = OUTPUT;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FINISH;
        end else begin
          wait_tick = 1'b1;
        end
      end
      OUTPUT: begin
        if (dout_valid_q && bus.dout_ready) begin
          xfer       = 1'b1;
          state_next = (remaining == 16'd1) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      ram_latch_q  <= 1'b0;
      ram_addr_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
`ifdef DNA_READER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      state       <= state_next;
      done        <= (state == FINISH);
      ram_latch_q <= fire;

      if (accept) begin
        addr      <= base_addr;
        remaining <= word_count;
        error     <= 1'b0;
        busy      <= 1'b1;
`ifdef DNA_READER_CHECKSUM_EN
        checksum  <= '0;
`endif
      end

      if (state == FINISH) begin
        busy <= 1'b0;
      end

      if (fire) begin
        ram_addr_q <= addr;
        wait_cnt   <= '0;
      end else if (wait_tick) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (timeout) begin
        error <= 1'b1;
      end

      if (capture) begin
        dout_q       <= bus.ram_data_out;
        dout_valid_q <= 1'b1;
      end

      // Address wraps naturally at 2^23; the count only reaches zero on the final transfer.
      if (xfer) begin
        dout_valid_q <= 1'b0;
        addr         <= addr + 23'd1;
        remaining    <= remaining - 16'd1;
`ifdef DNA_READER_CHECKSUM_EN
        checksum     <= checksum + dout_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
// Scoreboard bench for dna_reader: a block read of N words from base B must latch B+i (mod 2^23)
// and stream the RAM data in order, with the RAM model and downstream readiness randomized.
module tb_dna_reader;
  localparam int WAIT_LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [22:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        done;
  logic        error;
`ifdef DNA_READER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] exp_sum;
`endif

  dna_reader_if bus ();

  dna_reader #(
    .READ(1'b0),
    .WRITE(1'b1),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .busy(busy),
    .done(done),
    .error(error),
`ifdef DNA_READER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int latch_cnt = 0;
  int done_cnt = 0;
  int last_latch_cyc = 0;
  int blk_d0 = 0;
  int blk_l0 = 0;

  logic [22:0] exp_addr_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] key = 16'hA5A5;
  bit          ram_stuck = 1'b0;
  bit          stall = 1'b0;
  bit          rand_rdy = 1'b0;
  int          fixed_lat = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM controller: on a latch, drop ready, wait a latency, then return addr ^ key with ready high.
  initial begin : ram_model
    logic [22:0] a;
    int lat;
    bus.ram_ready    = 1'b1;
    bus.ram_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ram_latch === 1'b1 && !ram_stuck) begin
        a   = bus.ram_addr;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        bus.ram_ready    = 1'b0;
        bus.ram_data_out = 16'($urandom);
        repeat (1 + lat) @(posedge clk);
        #1;
        bus.ram_data_out = a[15:0] ^ key;
        bus.ram_ready    = 1'b1;
      end
    end
  end

  initial begin : ready_driver
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.dout_ready = stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin : monitor
    logic prev;
    logic [22:0] a;
    logic [15:0] w;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      if (bus.ram_latch) begin
        latch_cnt++;
        last_latch_cyc = cyc;
        check("latch_consecutive", 32'(prev), 32'd0);
        check("ram_instruction", 32'(bus.ram_instruction), 32'd0);
        if (exp_addr_q.size() == 0) fail_event("unexpected_latch", 32'(bus.ram_addr));
        else begin
          a = exp_addr_q.pop_front();
          check("ram_addr", 32'(bus.ram_addr), 32'(a));
        end
      end
      prev = bus.ram_latch;
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) fail_event("unexpected_dout", 32'(bus.dout));
        else begin
          w = exp_q.pop_front();
          check("dout", 32'(bus.dout), 32'(w));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_exp(input logic [22:0] b, input int n, input bit stuck);
    int a;
    logic [15:0] w;
    blk_d0 = done_cnt;
    blk_l0 = latch_cnt;
`ifdef DNA_READER_CHECKSUM_EN
    exp_sum = '0;
`endif
    for (int i = 0; i < n; i++) begin
      a = (int'(b) + i) & 32'h7FFFFF;
      exp_addr_q.push_back(23'(a));
      if (stuck) break;
      w = 16'(a) ^ key;
      exp_q.push_back(w);
`ifdef DNA_READER_CHECKSUM_EN
      exp_sum = exp_sum + w;
`endif
    end
  endtask

  task automatic do_start(input logic [22:0] b, input int n);
    base_addr  = b;
    word_count = 16'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
  endtask

  task automatic finish_block(input int n, input bit stuck, input int bound);
    int cycles;
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < bound) begin
      tick();
      cycles++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (n == 0) begin
      check("zero_done_latency", 32'(cycles), 32'd1);
      check("zero_no_latch", 32'(latch_cnt - blk_l0), 32'd0);
    end
    if (stuck) begin
      check("timeout_window",
            32'((cyc - last_latch_cyc) >= WAIT_LIMIT && (cyc - last_latch_cyc) <= WAIT_LIMIT + 2), 32'd1);
    end
    check("error_flag", 32'(error), 32'(stuck));
`ifdef DNA_READER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(exp_sum));
`endif
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_cnt - blk_d0), 32'd1);
    check("words_pending", 32'(exp_q.size()), 32'd0);
    check("latches_pending", 32'(exp_addr_q.size()), 32'd0);
    ram_stuck = 1'b0;
  endtask

  task automatic run_block(input logic [22:0] b, input int n, input bit stuck, input int bound);
    push_exp(b, n, stuck);
    ram_stuck = stuck;
    do_start(b, n);
    finish_block(n, stuck, bound);
  endtask

  task automatic check_reset_values();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ram_latch", 32'(bus.ram_latch), 32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_instruction", 32'(bus.ram_instruction), 32'd0);
`ifdef DNA_READER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [22:0] b;
    logic [15:0] held;
    int lc;
    int n;
    bit seen;

    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // Three-word read with always-ready downstream.
    key = 16'hA5A5;
    run_block(23'h000010, 3, 1'b0, 200);
    // Empty block: done two cycles after start, no RAM access.
    run_block(23'h000055, 0, 1'b0, 10);
    // Address wrap across the top of the space.
    run_block(23'h7FFFFF, 2, 1'b0, 200);

    // Downstream stall: word held, no new latch, a start while busy is ignored.
    b = 23'h001234;
    push_exp(b, 2, 1'b0);
    stall = 1'b1;
    do_start(b, 2);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (bus.dout_valid) seen = 1'b1;
    end
    check("stall_valid_seen", 32'(seen), 32'd1);
    held = bus.dout;
    check("stall_first_word", 32'(held), 32'(16'h1234 ^ key));
    lc = latch_cnt;
    base_addr  = 23'h003333;
    word_count = 16'd5;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("stall_dout_stable", 32'(bus.dout), 32'(held));
      check("stall_valid_held", 32'(bus.dout_valid), 32'd1);
      tick();
    end
    check("stall_no_latch", 32'(latch_cnt - lc), 32'd0);
    stall = 1'b0;
    finish_block(2, 1'b0, 200);

    // RAM never drops ready after the latch: timeout.
    run_block(23'h002000, 3, 1'b1, WAIT_LIMIT + 40);

    // Randomized blocks with random downstream readiness and RAM latency.
    rand_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      key = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? (23'h7FFFFF - 23'($urandom_range(0, 3))) : 23'($urandom);
      n = int'($urandom_range(0, 6));
      run_block(b, n, 1'b0, 150 + n * 60);
    end
    rand_rdy = 1'b0;

    // Reset while waiting for RAM data, then a clean read from a new base.
    key = 16'hA5A5;
    fixed_lat = 8;
    push_exp(23'h000100, 4, 1'b0);
    do_start(23'h000100, 4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.ram_latch) seen = 1'b1;
      else tick();
    end
    check("pre_reset_latch_seen", 32'(seen), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_latch", 32'(bus.ram_latch), 32'd0);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    fixed_lat = -1;
    key = 16'h0000;
    run_block(23'h000001, 3, 1'b0, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
